// File: rtl/alu_logic_pkg.sv
// Shared opcode definitions for the UART ALU logic unit and its command decoder.
package alu_logic_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] AND_OP  = 4'd0;
  localparam logic [OPW-1:0] OR_OP   = 4'd1;
  localparam logic [OPW-1:0] XOR_OP  = 4'd2;
  localparam logic [OPW-1:0] NAND_OP = 4'd3;
  localparam logic [OPW-1:0] NOR_OP  = 4'd4;
  localparam logic [OPW-1:0] XNOR_OP = 4'd5;
  localparam logic [OPW-1:0] NOT_OP  = 4'd6;
  localparam logic [OPW-1:0] PASS_OP = 4'd7;
  localparam logic [OPW-1:0] SHL_OP  = 4'd8;
  localparam logic [OPW-1:0] SHR_OP  = 4'd9;
  localparam logic [OPW-1:0] ASR_OP  = 4'd10;
  localparam logic [OPW-1:0] ROL_OP  = 4'd11;
  localparam logic [OPW-1:0] ROR_OP  = 4'd12;

  localparam logic [OPW-1:0] FIRST_ILLEGAL_OP = 4'd13;

endpackage

// File: rtl/alu_logic_func.sv
// Pure combinational logic/shift/rotate function; illegal opcodes give zero with err set.
module alu_logic_func
  import alu_logic_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic [N-1:0]   i_a_eff,
  input  logic [N-1:0]   i_b,
  input  logic [OPW-1:0] i_opcode,
  output logic [N-1:0]   o_res,
  output logic           o_err
);

  logic [SHW-1:0] w_sh;
  logic [2*N-1:0] w_rol;
  logic [2*N-1:0] w_ror;

  // Rotates shift a doubled copy of A; the wanted half then holds the wrapped bits.
  assign w_sh  = i_b[SHW-1:0];
  assign w_rol = {i_a_eff, i_a_eff} << w_sh;
  assign w_ror = {i_a_eff, i_a_eff} >> w_sh;

  always_comb begin
    o_res = '0;
    o_err = 1'b0;
    case (i_opcode)
      AND_OP:  o_res = i_a_eff & i_b;
      OR_OP:   o_res = i_a_eff | i_b;
      XOR_OP:  o_res = i_a_eff ^ i_b;
      NAND_OP: o_res = ~(i_a_eff & i_b);
      NOR_OP:  o_res = ~(i_a_eff | i_b);
      XNOR_OP: o_res = ~(i_a_eff ^ i_b);
      NOT_OP:  o_res = ~i_a_eff;
      PASS_OP: o_res = i_b;
      SHL_OP:  o_res = i_a_eff << w_sh;
      SHR_OP:  o_res = i_a_eff >> w_sh;
      ASR_OP:  o_res = $unsigned($signed(i_a_eff) >>> w_sh);
      ROL_OP:  o_res = w_rol[2*N-1:N];
      ROR_OP:  o_res = w_ror[N-1:0];
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready pipeline around alu_logic_func with chain mode and result flags.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [OPW-1:0] opcode,
  input  logic           chain,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out,
  output logic           flag_zero,
  output logic           flag_neg,
  output logic           flag_par,
  output logic           err
);

  logic           r_s1_valid;
  logic [N-1:0]   r_s1_a;
  logic [N-1:0]   r_s1_b;
  logic [OPW-1:0] r_s1_op;
  logic           r_s1_chain;

  logic           r_s2_valid;
  logic [N-1:0]   r_out;
  logic           r_zero;
  logic           r_neg;
  logic           r_par;
  logic           r_err;
  logic [N-1:0]   r_last;

  logic           w_s1_move;
  logic           w_accept;
  logic [N-1:0]   w_a_eff;
  logic [N-1:0]   w_res;
  logic           w_err;

  assign w_s1_move = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s1_move;
  assign w_accept  = in_valid && in_ready;
  // last_res is updated on the same edge a result enters S2, so a chained op in S1 never sees stale A.
  assign w_a_eff   = r_s1_chain ? r_last : r_s1_a;

  alu_logic_func #(
    .N   (N),
    .SHW (SHW)
  ) u_func (
    .i_a_eff  (w_a_eff),
    .i_b      (r_s1_b),
    .i_opcode (r_s1_op),
    .o_res    (w_res),
    .o_err    (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_chain <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= opcode;
      r_s1_chain <= chain;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zero     <= 1'b1;
      r_neg      <= 1'b0;
      r_par      <= 1'b0;
      r_err      <= 1'b0;
      r_last     <= '0;
    end else if (w_s1_move) begin
      r_s2_valid <= 1'b1;
      r_out      <= w_res;
      r_zero     <= (w_res == '0);
      r_neg      <= w_res[N-1];
      r_par      <= ^w_res;
      r_err      <= w_err;
      if (!w_err) r_last <= w_res;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out       = r_out;
  assign flag_zero = r_zero;
  assign flag_neg  = r_neg;
  assign flag_par  = r_par;
  assign err       = r_err;

endmodule

// File: doc/alu_logic_pipe.md
# alu_logic_pipe

Parametrised, pipelined successor to the combinational logic unit in the UART ALU datapath. It adds shift and rotate operations, result flags and an illegal-opcode error in place of X output. It also adds a chain mode that reuses the previous result as operand A, and valid/ready handshakes on both sides with full backpressure. It sits between the UART command decoder (upstream) and the response formatter (downstream).

## Interface
Parameters:
- N, 16: operand and result width; power of two, N ≥ 4.
- SHW, $clog2(N): shift-amount width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  N  operand A (signed).
- b  in  N  operand B; for shifts and rotates only b[SHW-1:0] is used.
- opcode  in  4  operation select.
- chain  in  1  1 = use the last result as A; the `a` port is ignored.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out  out  N  result (signed).
- flag_zero  out  1  out == 0.
- flag_neg  out  1  out[N-1].
- flag_par  out  1  XOR-reduce of out.
- err  out  1  opcode was illegal.

## Operation
Opcodes:
- 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT (~A), 7 PASS (B).
- 8 SHL: logical shift left.
- 9 SHR: logical shift right.
- 10 ASR: arithmetic shift right.
- 11 ROL: rotate left by b[SHW-1:0].
- 12 ROR: rotate right by b[SHW-1:0].
- 13–15 illegal: out = 0, err = 1, flags computed from out = 0.
- A shift amount of 0 returns A unchanged. Amounts are taken modulo N via the SHW-bit slice.

Pipeline stages:
- Stage S1 holds the captured operands, opcode and chain bit.
- Stage S2 holds the registered result and flags.
- The function is evaluated combinationally on the S1→S2 transfer.

Last-result register last_res:
- Loaded with each legal result as it enters S2.
- Illegal-opcode results leave it unchanged.
- A chained operation in S1 always sees the result of the immediately preceding legal operation, because transfers are in order. No hazard stall is needed.

Handshake:
- Accept on in_valid && in_ready.
- S1 moves to S2 when s1_valid && (!s2_valid || out_ready).
- in_ready = !s1_valid || (S1 moves this cycle). in_ready is combinational on out_ready.
- A result is consumed on out_valid && out_ready.
- Upstream must hold a/b/opcode/chain stable while in_valid && !in_ready.
- out and the flags hold stable while out_valid && !out_ready.

Reset:
- Asynchronous. Clears s1_valid, s2_valid and last_res to 0.
- Outputs go to: out_valid 0, in_ready 1 (after release), out 0, all flags 0 except flag_zero = 1, err 0.
- A reset mid-operation discards both stages; no result is emitted afterwards.

## Timing
- Latency: an operation accepted at edge E0 shows out_valid = 1 after E1 when S2 is free; 2 cycles accept-to-result.
- Throughput: 1 operation per cycle with out_ready held high.
- Simultaneous S2 drain and S1 load in the same cycle is required, so no bubble.
- Full condition: both stages valid and out_ready = 0 gives in_ready = 0. At most 2 operations are in flight.
- Empty condition: out_valid = 0, in_ready = 1.
- A chain op accepted while its predecessor is still in S1 is legal and yields the correct chained value.

## Structure
- Package alu_logic_pkg holds the opcode localparams (AND_OP..ROR_OP), the first illegal opcode (13) and the opcode width (4). It is shared with the decoder.
- Sub-module alu_logic_func is the pure combinational function: (a_eff, b, opcode) → (res, err). It is instantiated once between S1 and S2.
- The top level contains only the pipeline registers, last_res, the chain mux and the handshake logic.

## Test plan
1. N=16, AND, a=0x00FF, b=0x0F0F → out=0x000F, flag_par=0, flag_zero=0, err=0, out_valid 2 cycles after accept.
2. ASR a=0x8000 b=3 → 0xF000, flag_neg=1. ROR a=0x8001 b=4 → 0x1800. SHL a=0x0001 b=0x0010 (amount 0) → 0x0001.
3. Chain: OR a=0x00F0 b=0x000F → 0x00FF, then back-to-back XOR chain=1 a=0x1234 b=0x00FF → 0x0000 with flag_zero=1.
4. Illegal opcode 13 after a result of 0x00FF → out=0, err=1. A following AND chain=1 b=0xFFFF → 0x00FF.
5. Backpressure: hold out_ready=0 for 6 cycles while offering 4 operations. Exactly 2 are accepted and in_ready=0 from the third offer. After release, all 4 results appear in order with no loss or duplication.
6. Assert rst for 1 cycle with both stages full. out_valid drops immediately and stays 0, in_ready=1, and a subsequent chain op sees A=0.
